nibble_serial_adder: RTL and testbench

//   Multi-word serial add controller that drives the 4-bit ripple-carry adder one nibble per cycle.

---
 rtl/nibble_serial_adder.sv | 112 +++++++++++
 tb/tb_nibble_serial_adder.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: serial multi-word add controller for an external 4-bit
// ripple-carry adder. Operands are latched on start and fed to the adder one
// nibble per cycle. The adder's carry-out is fed back as the next carry-in, and
// each sum nibble is collected into sum_out.
module nibble_serial_adder #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] a_in,
  input  logic [4*NIBBLES-1:0] b_in,
  input  logic                 cin_in,
  output logic [3:0]           add_a,
  output logic [3:0]           add_b,
  output logic                 add_cin,
  input  logic [3:0]           add_s,
  input  logic                 add_cout,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] sum_out,
  output logic                 cout_out
);

  localparam int unsigned W  = 4 * NIBBLES;
  localparam int unsigned IW = $clog2(NIBBLES);
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [IW-1:0]   idx;
  logic            carry;
  logic [W-1:0]    a_reg;
  logic [W-1:0]    b_reg;
  logic [IW+1:0]   bit_base;

  // Bit offset of the current nibble within the operand words.
  assign bit_base = {idx, 2'b00};

  // Present the current nibble and carry to the adder while running, zero otherwise.
  always_comb begin
    add_a   = 4'd0;
    add_b   = 4'd0;
    add_cin = 1'b0;
    if (state == RUN) begin
      add_a   = a_reg[bit_base +: 4];
      add_b   = b_reg[bit_base +: 4];
      add_cin = carry;
    end
  end

  // Controller FSM: latch operands, step through the nibbles, pulse done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      carry    <= 1'b0;
      a_reg    <= '0;
      b_reg    <= '0;
      sum_out  <= '0;
      cout_out <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_reg    <= a_in;
            b_reg    <= b_in;
            carry    <= cin_in;
            idx      <= '0;
            sum_out  <= '0;
            cout_out <= 1'b0;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          sum_out[bit_base +: 4] <= add_s;
          carry                  <= add_cout;
          if (idx == LAST_IDX) begin
            // Last nibble: the adder carry-out becomes the final carry.
            cout_out <= add_cout;
            idx      <= '0;
            done     <= 1'b1;
            state    <= DONE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        DONE: begin
          // Result is valid for exactly this cycle; return to idle regardless of start.
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Testbench for nibble_serial_adder with a behavioural 4-bit adder on the add_* ports.
module tb_nibble_serial_adder;

  localparam int unsigned NIBBLES = 4;
  localparam int unsigned W       = 4 * NIBBLES;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a_in, b_in;
  logic         cin_in;
  logic [3:0]   add_a, add_b, add_s;
  logic         add_cin, add_cout;
  logic         busy, done;
  logic [W-1:0] sum_out;
  logic         cout_out;

  int nvec = 0;
  int nerr = 0;
  int ndone = 0;
  logic [W:0] exp_q[$];

  nibble_serial_adder #(.NIBBLES(NIBBLES)) dut (
    .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in), .cin_in(cin_in),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_s(add_s), .add_cout(add_cout),
    .busy(busy), .done(done), .sum_out(sum_out), .cout_out(cout_out)
  );

  // External 4-bit ripple-carry adder stand-in.
  logic [4:0] nib_sum;
  assign nib_sum  = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_cin};
  assign add_s    = nib_sum[3:0];
  assign add_cout = nib_sum[4];

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W:0] ref_sum(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic c);
    return {1'b0, a} + {1'b0, b} + (W+1)'(c);
  endfunction

  // Carry into nibble i is the carry out of the exact sum of the lower 4*i bits.
  function automatic logic ref_carry(input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic c, input int i);
    logic [W:0] m, t;
    m = ((W+1)'(1) << (4 * i)) - (W+1)'(1);
    t = ({1'b0, a} & m) + ({1'b0, b} & m) + (W+1)'(c);
    return t[4 * i];
  endfunction

  // Scoreboard: every done pulse retires the oldest expected result.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      ndone++;
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 64'(done), 64'(0));
      end else begin
        chk("result", 64'({cout_out, sum_out}), 64'(exp_q.pop_front()));
      end
    end
  end

  // Called at a negedge: wait for idle, apply start for one cycle, record expectation.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    int n = 0;
    while (busy !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("issue_timeout", 64'(busy), 64'(0));
    a_in = a; b_in = b; cin_in = c; start = 1'b1;
    exp_q.push_back(ref_sum(a, b, c));
    @(negedge clk);
    start = 1'b0;
  endtask

  // Issue one op and check adder drive on every RUN cycle, the done cycle and idle after.
  task automatic op_checked(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    logic [W-1:0] aa, bb;
    logic [W:0]   r;
    aa = a; bb = b;
    r = ref_sum(a, b, c);
    issue(a, b, c);
    for (int i = 0; i < int'(NIBBLES); i++) begin
      chk("run_busy", 64'(busy), 64'(1));
      chk("run_done", 64'(done), 64'(0));
      chk("add_a", 64'(add_a), 64'(aa[4*i +: 4]));
      chk("add_b", 64'(add_b), 64'(bb[4*i +: 4]));
      chk("add_cin", 64'(add_cin), 64'(ref_carry(a, b, c, i)));
      @(negedge clk);
    end
    chk("done_pulse", 64'(done), 64'(1));
    chk("done_busy", 64'(busy), 64'(1));
    chk("done_add_a", 64'(add_a), 64'(0));
    @(negedge clk);
    chk("idle_done", 64'(done), 64'(0));
    chk("idle_busy", 64'(busy), 64'(0));
    chk("idle_hold", 64'({cout_out, sum_out}), 64'(r));
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_done"}, 64'(done), 64'(0));
    chk({tag, "_add"}, 64'({add_a, add_b, add_cin}), 64'(0));
    chk({tag, "_sum"}, 64'({cout_out, sum_out}), 64'(0));
  endtask

  initial begin
    int d0;
    rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0; cin_in = 1'b0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Directed cases.
    op_checked(16'h1234, 16'h4321, 1'b0);
    op_checked(16'hFFFF, 16'h0001, 1'b0);
    op_checked(16'hFFFF, 16'hFFFF, 1'b1);
    op_checked(16'h8000, 16'h8000, 1'b0);
    op_checked(16'h0000, 16'h0000, 1'b1);

    // start held high with new operands during RUN/DONE is ignored.
    d0 = ndone;
    issue(16'h0F0F, 16'h0101, 1'b0);
    a_in = 16'hAAAA; b_in = 16'h5555; cin_in = 1'b1; start = 1'b1;
    for (int n = 0; n < 20 && busy !== 1'b0; n++) @(negedge clk);
    chk("held_first_result", 64'({cout_out, sum_out}), 64'(ref_sum(16'h0F0F, 16'h0101, 1'b0)));
    exp_q.push_back(ref_sum(16'hAAAA, 16'h5555, 1'b1));
    @(negedge clk);
    start = 1'b0;
    wait_drain();
    chk("held_done_count", 64'(ndone - d0), 64'(2));
    chk("held_second_result", 64'({cout_out, sum_out}), 64'(17'h10000));

    // Reset in the second RUN cycle aborts without a done pulse.
    d0 = ndone;
    issue(16'h1111, 16'h2222, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_zero("abort");
    void'(exp_q.pop_back());
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (NIBBLES + 2) @(negedge clk);
    chk("abort_no_done", 64'(ndone - d0), 64'(0));
    op_checked(16'h9876, 16'h6789, 1'b1);

    // Random back-to-back operations.
    d0 = ndone;
    for (int k = 0; k < 1000; k++) begin
      issue(W'($urandom), W'($urandom), 1'($urandom));
    end
    wait_drain();
    chk("random_done_count", 64'(ndone - d0), 64'(1000));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
